tx_sched: RTL and testbench
===========================

# tx_sched

Transmit frame scheduler for the VLC symbol encoder. It owns a two-bank ping-pong TX frame buffer that the host/MAC side fills, and it sequences the encoder one frame at a time. For each frame it pulses the encoder reset, generates the symbol-rate `next` strobe and serves buffer bytes at the encoder's address. It finishes a frame on the encoder's completion event, or aborts it on command or timeout.

## Interface
- `SYM_DIV`, 100: clock cycles per symbol; the period of `o_enc_next` (≥4).
- `GUARD_SYMS`, 2: extra `next` strobes issued after the completion event (≥1; the encoder uses one of them to clear its bins).
- `MAX_SYMS`, 1200: symbol-timeout limit per frame.
- `EV_COMPLETE`, 3-bit: encoder event code for "frame complete". Taken from the shared encoder header.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `i_wr_en` in 1: host byte write strobe into the fill bank.
- `i_wr_addr` in 7: host write address (0 = PHR length byte).
- `i_wr_data` in 8: host write data.
- `i_commit` in 1: single-cycle pulse; marks the fill bank ready to send.
- `i_abort` in 1: single-cycle pulse; abort the frame in flight.
- `o_buf_full` out 1: both banks hold committed frames.
- `o_commit_err` out 1: single-cycle pulse; commit rejected.
- `o_busy` out 1: a frame is in flight (any state other than IDLE).
- `o_tx_done` out 1: single-cycle pulse at end of frame.
- `o_tx_aborted` out 1: valid with `o_tx_done`; 1 = ended by abort or timeout.
- `o_enc_reset` out 1: reset to the encoder.
- `o_enc_next` out 1: symbol strobe to the encoder.
- `i_enc_addr` in 7: encoder buffer read address.
- `o_enc_byte` out 8: registered byte from the TX bank at `i_enc_addr`.
- `i_enc_ev` in 3: encoder current event code.
- `i_enc_ev_sig` in 1: pulse; `i_enc_ev` changed.

## Operation
- **Banks:** two 128×8 RAMs, write pointer `wp`, read pointer `rp`, count 0..2.
  - Host writes always go to bank `wp`.
  - A write to address 0 also latches `len[wp] = i_wr_data[6:0]`.
- **Commit:**
  - If count==2, or `len[wp]` < 2: pulse `o_commit_err`; no state change.
  - Otherwise: count+1 and `wp` toggles.
  - `o_buf_full` = (count==2).
- **FSM states:** IDLE, RST, RUN, GUARD, END.
- **IDLE → RST** when count>0. `o_enc_reset`=1 for exactly 1 cycle, then → RUN.
  - The symbol divider clears and `symcnt` clears.
- **RUN:**
  - Divider counts 0..SYM_DIV-1. `o_enc_next`=1 when the divider is at SYM_DIV-1, and `symcnt` increments.
  - `i_enc_ev_sig` with `i_enc_ev`==EV_COMPLETE → GUARD, guard counter cleared.
  - `symcnt`==MAX_SYMS → END, marked aborted.
- **GUARD:** the divider keeps running. After GUARD_SYMS further strobes → END, not aborted.
- **END** (1 cycle):
  - Pulse `o_tx_done` with `o_tx_aborted` valid.
  - Release the bank: `rp` toggles, count-1.
  - → IDLE. The next frame starts on the following cycle if count>0 after the release.
- **`i_abort`** in RST/RUN/GUARD: → END aborted. `o_enc_reset` is asserted on the next cycle (held until the next RST).
  - In IDLE or END it is ignored.
- **Simultaneous commit and release** (END): count = count+1-1; both pointers update.
  - The `o_commit_err` full check uses count before the release.
- **Encoder reset while idle:** `o_enc_reset` is held at 1 in IDLE and deasserted only after RST, so the encoder idles quiescent.

## Timing
- **Reset values:**
  - `o_enc_reset`=1.
  - `o_enc_next`, `o_busy`, `o_tx_done`, `o_tx_aborted`, `o_commit_err`, `o_buf_full` = 0.
  - `o_enc_byte`=0.
  - count=0, `wp`=`rp`=0, state IDLE.
- Reset mid-frame discards both banks.
- **Read latency:** `o_enc_byte` is valid 1 cycle after `i_enc_addr` changes; it always reads bank `rp`.
- **Start latency:** commit at cycle T (IDLE, count 0):
  - count=1 at T+1; RST at T+2 (`o_enc_reset`=1).
  - RUN from T+3; first `o_enc_next` at T+3+SYM_DIV-1.
- `o_enc_next` is high for 1 cycle, with period SYM_DIV.
- `o_commit_err` and `o_tx_done` are registered; each pulses the cycle after its cause.
- A host write and a commit in the same cycle: the write lands in the bank being committed.

## Test plan
- **Single frame:** write len=5 plus 3 PSDU bytes, commit; model the encoder to raise EV_COMPLETE after strobe 60.
  - Expect exactly 62 `o_enc_next` strobes, spaced 100 cycles apart.
  - Expect `o_tx_done`=1 and `o_tx_aborted`=0.
- **Back-to-back:** commit two frames (count→2, `o_buf_full`=1); a third commit pulses `o_commit_err`.
  - The frames transmit in order with one `o_enc_reset` pulse between them.
  - `o_buf_full` drops at the first END.
- **Bad length:** commit with the byte 0 write = 8'h01 → `o_commit_err` pulse; count stays 0; `o_busy` stays 0.
- **Abort:** pulse `i_abort` after strobe 10.
  - `o_tx_done` with `o_tx_aborted`=1 next cycle; `o_enc_reset`=1 the cycle after.
  - No further strobes; the bank is released.
- **Timeout:** the encoder never completes → END after 1200 strobes, aborted=1.
- **Reset mid-RUN:** all outputs return to reset values; no `o_tx_done`; count=0.

Source files
------------

// File: rtl/tx_sched.sv
// -----------------------------------------------------------------------------
// tx_sched : transmit frame scheduler for the VLC symbol encoder
//
// Owns a two-bank ping-pong TX frame buffer. The host fills bank `wp` and
// commits it. The scheduler then drains bank `rp` one frame at a time. For each
// frame it pulses the encoder reset, generates the symbol-rate `next` strobe and
// serves buffer bytes at the encoder's read address. A frame ends in one of
// three ways:
//   - normally, GUARD_SYMS strobes after the encoder reports EV_COMPLETE;
//   - on an abort command;
//   - on a symbol timeout (MAX_SYMS strobes without completion).
//
// Parameters
//   SYM_DIV      clock cycles per symbol (period of o_enc_next, >= 4)
//   GUARD_SYMS   strobes issued after the completion event (>= 1)
//   MAX_SYMS     symbol timeout per frame
//   EV_COMPLETE  encoder event code meaning "frame complete"
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   i_wr_en/addr/data       host byte writes into the fill bank (addr 0 = length)
//   i_commit                pulse: fill bank ready to send
//   i_abort                 pulse: abort the frame in flight
//   o_buf_full              both banks hold committed frames
//   o_commit_err            pulse: commit rejected (full or length < 2)
//   o_busy                  a frame is in flight
//   o_tx_done, o_tx_aborted end-of-frame pulse and its abort/timeout flag
//   o_enc_reset, o_enc_next encoder reset and symbol strobe
//   i_enc_addr, o_enc_byte  encoder read port (1-cycle latency, bank rp)
//   i_enc_ev, i_enc_ev_sig  encoder event code and change strobe
// -----------------------------------------------------------------------------
module tx_sched #(
  parameter int         SYM_DIV     = 100,
  parameter int         GUARD_SYMS  = 2,
  parameter int         MAX_SYMS    = 1200,
  parameter logic [2:0] EV_COMPLETE = 3'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_wr_en,
  input  logic [6:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  input  logic       i_commit,
  input  logic       i_abort,
  output logic       o_buf_full,
  output logic       o_commit_err,
  output logic       o_busy,
  output logic       o_tx_done,
  output logic       o_tx_aborted,
  output logic       o_enc_reset,
  output logic       o_enc_next,
  input  logic [6:0] i_enc_addr,
  output logic [7:0] o_enc_byte,
  input  logic [2:0] i_enc_ev,
  input  logic       i_enc_ev_sig
);

  localparam int DIV_W = $clog2(SYM_DIV);
  localparam int SYM_W = $clog2(MAX_SYMS + 1);
  localparam int GRD_W = $clog2(GUARD_SYMS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SYM_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE   = DIV_W'(SYM_DIV - 2);
  localparam logic [SYM_W-1:0] SYM_LIMIT = SYM_W'(MAX_SYMS);
  localparam logic [GRD_W-1:0] GRD_LAST  = GRD_W'(GUARD_SYMS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_RUN   = 3'd2,
    S_GUARD = 3'd3,
    S_END   = 3'd4
  } state_t;

  // Buffer bookkeeping
  logic [7:0]      mem0_r [0:127];
  logic [7:0]      mem1_r [0:127];
  logic [1:0][6:0] len_r;
  logic            wp_r;
  logic            rp_r;
  logic [1:0]      count_r;
  logic            commit_err_r;
  logic            buf_full_r;
  logic [7:0]      enc_byte_r;

  // Sequencer
  state_t          state_r;
  logic [DIV_W-1:0] div_r;
  logic [SYM_W-1:0] symcnt_r;
  logic [GRD_W-1:0] guard_r;
  logic            enc_reset_r;
  logic            enc_next_r;
  logic            busy_r;
  logic            tx_done_r;
  logic            tx_aborted_r;

  // Combinational decisions
  logic            release_s;
  logic            len_ok_s;
  logic            commit_ok_s;
  logic            ev_complete_s;
  logic [1:0]      count_next_s;

  // Commit acceptance and next buffer count (commit and release may coincide)
  always_comb begin
    release_s     = (state_r == S_END);
    len_ok_s      = (len_r[wp_r] >= 7'd2);
    // The full check deliberately uses the count before any same-cycle release
    commit_ok_s   = i_commit && (count_r != 2'd2) && len_ok_s;
    ev_complete_s = i_enc_ev_sig && (i_enc_ev == EV_COMPLETE);
    case ({commit_ok_s, release_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // Bank pointers, frame count, per-bank length and commit status
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_r         <= 1'b0;
      rp_r         <= 1'b0;
      count_r      <= 2'd0;
      len_r        <= '0;
      commit_err_r <= 1'b0;
      buf_full_r   <= 1'b0;
    end else begin
      if (i_wr_en && (i_wr_addr == 7'd0)) begin
        len_r[wp_r] <= i_wr_data[6:0];
      end
      commit_err_r <= i_commit && !commit_ok_s;
      if (commit_ok_s) begin
        wp_r <= ~wp_r;
      end
      if (release_s) begin
        rp_r <= ~rp_r;
      end
      count_r    <= count_next_s;
      buf_full_r <= (count_next_s == 2'd2);
    end
  end

  // Host write port: writes always land in the fill bank, including during a commit
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      if (wp_r) begin
        mem1_r[i_wr_addr] <= i_wr_data;
      end else begin
        mem0_r[i_wr_addr] <= i_wr_data;
      end
    end
  end

  // Encoder read port: registered byte from the transmit bank
  always_ff @(posedge clk) begin
    if (reset) begin
      enc_byte_r <= 8'd0;
    end else begin
      enc_byte_r <= rp_r ? mem1_r[i_enc_addr] : mem0_r[i_enc_addr];
    end
  end

  // Frame sequencer: encoder reset, symbol divider, completion/abort/timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      div_r        <= '0;
      symcnt_r     <= '0;
      guard_r      <= '0;
      enc_reset_r  <= 1'b1;
      enc_next_r   <= 1'b0;
      busy_r       <= 1'b0;
      tx_done_r    <= 1'b0;
      tx_aborted_r <= 1'b0;
    end else begin
      tx_done_r    <= 1'b0;
      tx_aborted_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          // Encoder stays in reset while idle so it sits quiescent
          enc_reset_r <= 1'b1;
          enc_next_r  <= 1'b0;
          div_r       <= '0;
          symcnt_r    <= '0;
          guard_r     <= '0;
          if (count_r != 2'd0) begin
            state_r <= S_RST;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        S_RST: begin
          div_r    <= '0;
          symcnt_r <= '0;
          if (i_abort) begin
            state_r      <= S_END;
            tx_done_r    <= 1'b1;
            tx_aborted_r <= 1'b1;
          end else begin
            state_r     <= S_RUN;
            enc_reset_r <= 1'b0;
          end
        end
        S_RUN, S_GUARD: begin
          // Divider runs through RUN and GUARD without a phase break;
          // the strobe is registered one count ahead so it lines up with DIV_LAST
          div_r      <= (div_r == DIV_LAST) ? '0 : div_r + DIV_W'(1);
          enc_next_r <= (div_r == DIV_PRE);
          if (i_abort) begin
            state_r      <= S_END;
            enc_next_r   <= 1'b0;
            tx_done_r    <= 1'b1;
            tx_aborted_r <= 1'b1;
          end else if (state_r == S_RUN) begin
            if (enc_next_r) begin
              symcnt_r <= symcnt_r + SYM_W'(1);
            end
            if (ev_complete_s) begin
              state_r <= S_GUARD;
              guard_r <= '0;
            end else if (symcnt_r == SYM_LIMIT) begin
              state_r      <= S_END;
              enc_next_r   <= 1'b0;
              tx_done_r    <= 1'b1;
              tx_aborted_r <= 1'b1;
            end else begin
              state_r <= S_RUN;
            end
          end else begin
            if (enc_next_r) begin
              if (guard_r == GRD_LAST) begin
                state_r      <= S_END;
                enc_next_r   <= 1'b0;
                tx_done_r    <= 1'b1;
                tx_aborted_r <= 1'b0;
              end else begin
                guard_r <= guard_r + GRD_W'(1);
              end
            end
          end
        end
        S_END: begin
          // Bank release happens in the buffer block; restart is decided in IDLE
          state_r     <= S_IDLE;
          busy_r      <= 1'b0;
          enc_reset_r <= 1'b1;
          enc_next_r  <= 1'b0;
        end
        default: begin
          state_r     <= S_IDLE;
          busy_r      <= 1'b0;
          enc_reset_r <= 1'b1;
          enc_next_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_buf_full   = buf_full_r;
  assign o_commit_err = commit_err_r;
  assign o_busy       = busy_r;
  assign o_tx_done    = tx_done_r;
  assign o_tx_aborted = tx_aborted_r;
  assign o_enc_reset  = enc_reset_r;
  assign o_enc_next   = enc_next_r;
  assign o_enc_byte   = enc_byte_r;

endmodule

// File: tb/tb_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_tx_sched : directed self-checking bench for tx_sched.
// The symbol divider is shortened to 20 cycles to keep run time small; all
// strobe counts follow the design's own rules (GUARD_SYMS=2, MAX_SYMS=1200).
// -----------------------------------------------------------------------------
module tb_tx_sched;

  localparam int         SYM_DIV = 20;
  localparam int         GUARD   = 2;
  localparam int         MAXS    = 1200;
  localparam logic [2:0] EV_C    = 3'd4;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_wr_en;
  logic [6:0] i_wr_addr;
  logic [7:0] i_wr_data;
  logic       i_commit;
  logic       i_abort;
  logic       o_buf_full;
  logic       o_commit_err;
  logic       o_busy;
  logic       o_tx_done;
  logic       o_tx_aborted;
  logic       o_enc_reset;
  logic       o_enc_next;
  logic [6:0] i_enc_addr;
  logic [7:0] o_enc_byte;
  logic [2:0] i_enc_ev;
  logic       i_enc_ev_sig;

  always #5 clk = ~clk;

  tx_sched #(.SYM_DIV(SYM_DIV), .GUARD_SYMS(GUARD), .MAX_SYMS(MAXS), .EV_COMPLETE(EV_C)) dut (
    .clk(clk), .reset(reset),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_commit(i_commit), .i_abort(i_abort),
    .o_buf_full(o_buf_full), .o_commit_err(o_commit_err), .o_busy(o_busy),
    .o_tx_done(o_tx_done), .o_tx_aborted(o_tx_aborted),
    .o_enc_reset(o_enc_reset), .o_enc_next(o_enc_next),
    .i_enc_addr(i_enc_addr), .o_enc_byte(o_enc_byte),
    .i_enc_ev(i_enc_ev), .i_enc_ev_sig(i_enc_ev_sig)
  );

  int checks   = 0;
  int failures = 0;

  // Monitor (sole writer of these): strobe count/spacing, done events, reset rises
  int   cyc         = 0;
  int   strobe_cnt  = 0;
  int   gap_bad     = 0;
  int   done_cnt    = 0;
  int   rst_rise    = 0;
  int   last_strobe = -1;
  logic prev_reset  = 1'b1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (o_enc_reset && !prev_reset) rst_rise = rst_rise + 1;
    prev_reset = o_enc_reset;
    if (o_enc_reset) last_strobe = -1;
    if (o_enc_next) begin
      if (last_strobe >= 0 && (cyc - last_strobe) != SYM_DIV) gap_bad = gap_bad + 1;
      last_strobe = cyc;
      strobe_cnt  = strobe_cnt + 1;
    end
    if (o_tx_done) done_cnt = done_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic write_byte(input logic [6:0] a, input logic [7:0] d);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
    tick(1);
    i_wr_en = 1'b0;
  endtask

  task automatic do_commit;
    i_commit = 1'b1;
    tick(1);
    i_commit = 1'b0;
  endtask

  task automatic ev_pulse(input logic [2:0] code);
    i_enc_ev = code; i_enc_ev_sig = 1'b1;
    tick(1);
    i_enc_ev_sig = 1'b0;
  endtask

  task automatic wait_strobes(input int base, input int n, input string tag);
    int budget;
    budget = (n + 2) * SYM_DIV + 20;
    while ((strobe_cnt - base) < n && budget > 0) begin tick(1); budget--; end
    if ((strobe_cnt - base) < n) begin
      $display("FAIL %s_wait: strobes seen %0d, required %0d", tag, strobe_cnt - base, n);
      failures++;
    end
    checks++;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int b;
    b = budget;
    while (!o_tx_done && b > 0) begin tick(1); b--; end
    if (o_tx_done !== 1'b1) begin
      $display("FAIL %s_done: o_tx_done=%b, required 1 within %0d cycles", tag, o_tx_done, budget);
      failures++;
    end
    checks++;
  endtask

  task automatic test_reset;
    reset = 1'b1; i_wr_en = 1'b0; i_wr_addr = 7'd0; i_wr_data = 8'd0; i_commit = 1'b0;
    i_abort = 1'b0; i_enc_addr = 7'd0; i_enc_ev = 3'd0; i_enc_ev_sig = 1'b0;
    tick(3);
    if (o_enc_reset !== 1'b1)  begin $display("FAIL rst_enc_reset: got %b want 1", o_enc_reset); failures++; end checks++;
    if (o_enc_next !== 1'b0)   begin $display("FAIL rst_enc_next: got %b want 0", o_enc_next); failures++; end checks++;
    if (o_busy !== 1'b0)       begin $display("FAIL rst_busy: got %b want 0", o_busy); failures++; end checks++;
    if (o_tx_done !== 1'b0)    begin $display("FAIL rst_tx_done: got %b want 0", o_tx_done); failures++; end checks++;
    if (o_tx_aborted !== 1'b0) begin $display("FAIL rst_tx_aborted: got %b want 0", o_tx_aborted); failures++; end checks++;
    if (o_commit_err !== 1'b0) begin $display("FAIL rst_commit_err: got %b want 0", o_commit_err); failures++; end checks++;
    if (o_buf_full !== 1'b0)   begin $display("FAIL rst_buf_full: got %b want 0", o_buf_full); failures++; end checks++;
    if (o_enc_byte !== 8'h00)  begin $display("FAIL rst_enc_byte: got %h want 00", o_enc_byte); failures++; end checks++;
    reset = 1'b0;
    tick(2);
    if (o_busy !== 1'b0 || o_enc_reset !== 1'b1) begin
      $display("FAIL idle_after_rst: busy=%b enc_reset=%b want 0/1", o_busy, o_enc_reset); failures++;
    end
    checks++;
  endtask

  task automatic test_single_frame;
    int sbase, gbase;
    write_byte(7'd0, 8'd5); write_byte(7'd1, 8'hA1); write_byte(7'd2, 8'hB2); write_byte(7'd3, 8'hC3);
    sbase = strobe_cnt; gbase = gap_bad;
    do_commit;                                           // now cycle T+1
    if (o_busy !== 1'b0) begin $display("FAIL sf_t1_busy: got %b want 0", o_busy); failures++; end checks++;
    tick(1);                                             // T+2: RST
    if (o_busy !== 1'b1 || o_enc_reset !== 1'b1) begin
      $display("FAIL sf_t2_rst: busy=%b enc_reset=%b want 1/1", o_busy, o_enc_reset); failures++;
    end
    checks++;
    tick(1);                                             // T+3: RUN
    if (o_enc_reset !== 1'b0) begin $display("FAIL sf_t3_enc_reset: got %b want 0", o_enc_reset); failures++; end checks++;
    tick(SYM_DIV - 2);
    if (o_enc_next !== 1'b0) begin $display("FAIL sf_early_next: got %b want 0", o_enc_next); failures++; end checks++;
    tick(1);                                             // T+3+SYM_DIV-1
    if (o_enc_next !== 1'b1) begin $display("FAIL sf_first_next: got %b want 1", o_enc_next); failures++; end checks++;
    i_enc_addr = 7'd0; tick(1);
    if (o_enc_byte !== 8'h05) begin $display("FAIL sf_byte0: got %h want 05", o_enc_byte); failures++; end checks++;
    i_enc_addr = 7'd2; tick(1);
    if (o_enc_byte !== 8'hB2) begin $display("FAIL sf_byte2: got %h want b2", o_enc_byte); failures++; end checks++;
    i_enc_addr = 7'd3; tick(1);
    if (o_enc_byte !== 8'hC3) begin $display("FAIL sf_byte3: got %h want c3", o_enc_byte); failures++; end checks++;
    wait_strobes(sbase, 30, "sf30");
    ev_pulse(3'd2);                                      // non-completion event: ignored
    wait_strobes(sbase, 60, "sf60");
    tick(3);
    ev_pulse(EV_C);
    wait_done(6 * SYM_DIV, "sf");
    if (o_tx_aborted !== 1'b0) begin $display("FAIL sf_aborted: got %b want 0", o_tx_aborted); failures++; end checks++;
    if (strobe_cnt - sbase !== 62) begin $display("FAIL sf_strobes: got %0d want 62", strobe_cnt - sbase); failures++; end checks++;
    if (gap_bad - gbase !== 0) begin $display("FAIL sf_spacing: bad gaps %0d want 0", gap_bad - gbase); failures++; end checks++;
    tick(1);
    if (o_busy !== 1'b0 || o_enc_reset !== 1'b1 || o_tx_done !== 1'b0) begin
      $display("FAIL sf_after_end: busy=%b enc_reset=%b done=%b want 0/1/0", o_busy, o_enc_reset, o_tx_done); failures++;
    end
    checks++;
  endtask

  task automatic test_bad_length;
    int busy_seen;
    write_byte(7'd0, 8'h01);
    do_commit;
    if (o_commit_err !== 1'b1) begin $display("FAIL bl_err: got %b want 1", o_commit_err); failures++; end checks++;
    tick(1);
    if (o_commit_err !== 1'b0) begin $display("FAIL bl_err_pulse: got %b want 0", o_commit_err); failures++; end checks++;
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin if (o_busy) busy_seen = 1; tick(1); end
    if (busy_seen !== 0) begin $display("FAIL bl_busy: got %0d want 0", busy_seen); failures++; end checks++;
  endtask

  task automatic test_back_to_back;
    int sbase, rbase;
    write_byte(7'd0, 8'd4); write_byte(7'd1, 8'h11);
    sbase = strobe_cnt;
    do_commit;
    write_byte(7'd0, 8'd6); write_byte(7'd1, 8'h22);
    do_commit;
    if (o_buf_full !== 1'b1 || o_commit_err !== 1'b0) begin
      $display("FAIL bb_full: full=%b err=%b want 1/0", o_buf_full, o_commit_err); failures++;
    end
    checks++;
    do_commit;
    if (o_commit_err !== 1'b1 || o_buf_full !== 1'b1) begin
      $display("FAIL bb_third_commit: err=%b full=%b want 1/1", o_commit_err, o_buf_full); failures++;
    end
    checks++;
    i_enc_addr = 7'd1; tick(2);
    if (o_enc_byte !== 8'h11) begin $display("FAIL bb_f1_byte: got %h want 11", o_enc_byte); failures++; end checks++;
    wait_strobes(sbase, 5, "bb1");
    tick(2);
    ev_pulse(EV_C);
    wait_done(6 * SYM_DIV, "bb1");
    if (o_tx_aborted !== 1'b0) begin $display("FAIL bb1_aborted: got %b want 0", o_tx_aborted); failures++; end checks++;
    if (strobe_cnt - sbase !== 7) begin $display("FAIL bb1_strobes: got %0d want 7", strobe_cnt - sbase); failures++; end checks++;
    sbase = strobe_cnt; rbase = rst_rise;
    tick(1);
    if (o_buf_full !== 1'b0 || o_busy !== 1'b0 || o_enc_reset !== 1'b1) begin
      $display("FAIL bb_release: full=%b busy=%b enc_reset=%b want 0/0/1", o_buf_full, o_busy, o_enc_reset); failures++;
    end
    checks++;
    tick(1);
    if (o_busy !== 1'b1) begin $display("FAIL bb_f2_start: busy=%b want 1", o_busy); failures++; end checks++;
    wait_strobes(sbase, 1, "bb2a");
    if (rst_rise - rbase !== 1) begin $display("FAIL bb_reset_pulses: got %0d want 1", rst_rise - rbase); failures++; end checks++;
    if (o_enc_byte !== 8'h22) begin $display("FAIL bb_f2_byte: got %h want 22", o_enc_byte); failures++; end checks++;
    wait_strobes(sbase, 3, "bb2b");
    tick(2);
    ev_pulse(EV_C);
    wait_done(6 * SYM_DIV, "bb2");
    if (o_tx_aborted !== 1'b0) begin $display("FAIL bb2_aborted: got %b want 0", o_tx_aborted); failures++; end checks++;
    if (strobe_cnt - sbase !== 5) begin $display("FAIL bb2_strobes: got %0d want 5", strobe_cnt - sbase); failures++; end checks++;
    tick(3);
  endtask

  task automatic test_abort;
    int sbase, busy_seen;
    write_byte(7'd0, 8'd5);
    sbase = strobe_cnt;
    do_commit;
    wait_strobes(sbase, 10, "ab");
    tick(2);
    i_abort = 1'b1; tick(1); i_abort = 1'b0;
    if (o_tx_done !== 1'b1 || o_tx_aborted !== 1'b1) begin
      $display("FAIL ab_done: done=%b aborted=%b want 1/1", o_tx_done, o_tx_aborted); failures++;
    end
    checks++;
    tick(1);
    if (o_enc_reset !== 1'b1 || o_tx_done !== 1'b0) begin
      $display("FAIL ab_enc_reset: enc_reset=%b done=%b want 1/0", o_enc_reset, o_tx_done); failures++;
    end
    checks++;
    busy_seen = 0;
    for (int i = 0; i < 3 * SYM_DIV; i++) begin if (o_busy) busy_seen = 1; tick(1); end
    if (strobe_cnt - sbase !== 10) begin $display("FAIL ab_strobes: got %0d want 10", strobe_cnt - sbase); failures++; end checks++;
    if (busy_seen !== 0) begin $display("FAIL ab_released: busy seen %0d want 0", busy_seen); failures++; end checks++;
  endtask

  task automatic test_timeout;
    int sbase, gbase;
    write_byte(7'd0, 8'd2);
    sbase = strobe_cnt; gbase = gap_bad;
    do_commit;
    wait_done((MAXS + 4) * SYM_DIV, "to");
    if (o_tx_aborted !== 1'b1) begin $display("FAIL to_aborted: got %b want 1", o_tx_aborted); failures++; end checks++;
    if (strobe_cnt - sbase !== MAXS) begin $display("FAIL to_strobes: got %0d want %0d", strobe_cnt - sbase, MAXS); failures++; end checks++;
    if (gap_bad - gbase !== 0) begin $display("FAIL to_spacing: bad gaps %0d want 0", gap_bad - gbase); failures++; end checks++;
    tick(3);
  endtask

  task automatic test_reset_mid_run;
    int sbase, dbase, busy_seen;
    write_byte(7'd0, 8'd3);
    sbase = strobe_cnt;
    do_commit;
    write_byte(7'd0, 8'd2);
    do_commit;
    if (o_buf_full !== 1'b1) begin $display("FAIL rm_full: got %b want 1", o_buf_full); failures++; end checks++;
    wait_strobes(sbase, 5, "rm");
    dbase = done_cnt;
    reset = 1'b1; tick(2);
    if (o_enc_reset !== 1'b1 || o_enc_next !== 1'b0 || o_busy !== 1'b0 || o_tx_done !== 1'b0 ||
        o_tx_aborted !== 1'b0 || o_buf_full !== 1'b0 || o_commit_err !== 1'b0 || o_enc_byte !== 8'h00) begin
      $display("FAIL rm_outputs: rst=%b nxt=%b busy=%b done=%b ab=%b full=%b err=%b byte=%h want 1/0/0/0/0/0/0/00",
               o_enc_reset, o_enc_next, o_busy, o_tx_done, o_tx_aborted, o_buf_full, o_commit_err, o_enc_byte);
      failures++;
    end
    checks++;
    reset = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 3 * SYM_DIV; i++) begin if (o_busy) busy_seen = 1; tick(1); end
    if (busy_seen !== 0) begin $display("FAIL rm_count_zero: busy seen %0d want 0", busy_seen); failures++; end checks++;
    if (done_cnt - dbase !== 0) begin $display("FAIL rm_no_done: got %0d want 0", done_cnt - dbase); failures++; end checks++;
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_bad_length;
    test_back_to_back;
    test_abort;
    test_timeout;
    test_reset_mid_run;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
